// File: rtl/cnn_pkg.sv
// Shared constants, widths and state encoding for the CNN inference engine.
package cnn_pkg;

  localparam int IMG_W    = 28;
  localparam int KSIZE    = 3;
  localparam int OUT_W    = IMG_W - KSIZE + 1;
  localparam int NUM_FILT = 4;
  localparam int NUM_CLS  = 10;
  localparam int FM_SIZE  = NUM_FILT * OUT_W * OUT_W;
  localparam int ACC_W    = 32;

  localparam int FILT_W  = 2;
  localparam int COORD_W = 5;
  localparam int ADDR_W  = 12;
  localparam int CLS_W   = 4;

  localparam logic [FILT_W-1:0]  LAST_FILT  = FILT_W'(NUM_FILT - 1);
  localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(OUT_W - 1);
  localparam logic [CLS_W-1:0]   LAST_CLS   = CLS_W'(NUM_CLS - 1);

  // Weight-stream sizes shared with the weight loader.
  localparam int CONV_W_WORDS     = NUM_FILT * KSIZE * KSIZE;
  localparam int CONV_BIAS_BYTES  = NUM_FILT * 4;
  localparam int DENSE_W_WORDS    = FM_SIZE * NUM_CLS;
  localparam int DENSE_BIAS_BYTES = NUM_CLS * 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CONV_ISSUE  = 3'd1,
    S_CONV_WAIT   = 3'd2,
    S_DENSE_ISSUE = 3'd3,
    S_DENSE_WAIT  = 3'd4,
    S_DONE        = 3'd5
  } state_t;

endpackage

// File: rtl/cnn_argmax.sv
// Streaming argmax: keeps the index and value of the largest signed input.
// Index 0 loads unconditionally; later indices replace only on a strictly
// greater value, so ties resolve to the lower index.
module cnn_argmax
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    valid,
  input  logic [CLS_W-1:0]        idx,
  input  logic signed [ACC_W-1:0] value,
  output logic [CLS_W-1:0]        best_idx,
  output logic signed [ACC_W-1:0] best_val
);

  logic [CLS_W-1:0]        best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0] best_val_q, best_val_d;

  // Next best: clear wins, otherwise load on first index or strict improvement.
  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clear) begin
      best_idx_d = '0;
      best_val_d = '0;
    end else if (valid && ((idx == '0) || (value > best_val_q))) begin
      best_idx_d = idx;
      best_val_d = value;
    end
  end

  // Register the running maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign best_idx = best_idx_q;
  assign best_val = best_val_q;

endmodule

// File: rtl/cnn_inference_sequencer.sv
// Inference controller: walks every conv output pixel (filter, row, col),
// then every dense neuron, feeds dense results to the argmax and reports
// the winning class. All outputs come straight from flops.
module cnn_inference_sequencer
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weights_ready,
  input  logic                    image_ready,
  input  logic                    start,
  output logic                    start_rejected,
  output logic                    busy,
  output logic                    conv_start,
  output logic [FILT_W-1:0]       conv_filt,
  output logic [COORD_W-1:0]      conv_row,
  output logic [COORD_W-1:0]      conv_col,
  output logic [ADDR_W-1:0]       fm_addr,
  input  logic                    conv_done,
  output logic                    dense_start,
  output logic [CLS_W-1:0]        dense_idx,
  input  logic                    dense_done,
  input  logic signed [ACC_W-1:0] dense_acc,
  output logic                    image_release,
  output logic                    result_valid,
  output logic [CLS_W-1:0]        result_class,
  output logic signed [ACC_W-1:0] result_score
);

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    start_rejected_q, start_rejected_d;
  logic                    conv_start_q, conv_start_d;
  logic [FILT_W-1:0]       filt_q, filt_d;
  logic [COORD_W-1:0]      row_q, row_d;
  logic [COORD_W-1:0]      col_q, col_d;
  logic [ADDR_W-1:0]       fm_addr_q, fm_addr_d;
  logic                    dense_start_q, dense_start_d;
  logic [CLS_W-1:0]        dense_idx_q, dense_idx_d;
  logic                    image_release_q, image_release_d;
  logic                    result_valid_q, result_valid_d;
  logic [CLS_W-1:0]        result_class_q, result_class_d;
  logic signed [ACC_W-1:0] result_score_q, result_score_d;

  logic                    am_clear;
  logic                    am_valid;
  logic [CLS_W-1:0]        am_best_idx;
  logic signed [ACC_W-1:0] am_best_val;
  logic                    last_pixel;

  assign last_pixel = (filt_q == LAST_FILT) && (row_q == LAST_COORD) && (col_q == LAST_COORD);
  assign am_valid   = (state_q == S_DENSE_WAIT) && dense_done;

  cnn_argmax u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clear    (am_clear),
    .valid    (am_valid),
    .idx      (dense_idx_q),
    .value    (dense_acc),
    .best_idx (am_best_idx),
    .best_val (am_best_val)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    start_rejected_d = 1'b0;
    conv_start_d     = 1'b0;
    filt_d           = filt_q;
    row_d            = row_q;
    col_d            = col_q;
    fm_addr_d        = fm_addr_q;
    dense_start_d    = 1'b0;
    dense_idx_d      = dense_idx_q;
    image_release_d  = 1'b0;
    result_valid_d   = 1'b0;
    result_class_d   = result_class_q;
    result_score_d   = result_score_q;
    am_clear         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (weights_ready && image_ready) begin
            state_d        = S_CONV_ISSUE;
            busy_d         = 1'b1;
            filt_d         = '0;
            row_d          = '0;
            col_d          = '0;
            fm_addr_d      = '0;
            dense_idx_d    = '0;
            result_class_d = '0;
            result_score_d = '0;
            am_clear       = 1'b1;
          end else begin
            start_rejected_d = 1'b1;
          end
        end
      end
      S_CONV_ISSUE: begin
        conv_start_d = 1'b1;
        state_d      = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        if (conv_done) begin
          if (last_pixel) begin
            filt_d          = '0;
            row_d           = '0;
            col_d           = '0;
            fm_addr_d       = '0;
            image_release_d = 1'b1;
            state_d         = S_DENSE_ISSUE;
          end else begin
            // fm_addr tracks filter/row/col as a flat running count.
            fm_addr_d = fm_addr_q + 1'b1;
            if (col_q == LAST_COORD) begin
              col_d = '0;
              if (row_q == LAST_COORD) begin
                row_d  = '0;
                filt_d = filt_q + 1'b1;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
            state_d = S_CONV_ISSUE;
          end
        end
      end
      S_DENSE_ISSUE: begin
        dense_start_d = 1'b1;
        state_d       = S_DENSE_WAIT;
      end
      S_DENSE_WAIT: begin
        if (dense_done) begin
          if (dense_idx_q == LAST_CLS) begin
            dense_idx_d = '0;
            state_d     = S_DONE;
          end else begin
            dense_idx_d = dense_idx_q + 1'b1;
            state_d     = S_DENSE_ISSUE;
          end
        end
      end
      S_DONE: begin
        result_valid_d = 1'b1;
        result_class_d = am_best_idx;
        result_score_d = am_best_val;
        busy_d         = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      start_rejected_q <= 1'b0;
      conv_start_q     <= 1'b0;
      filt_q           <= '0;
      row_q            <= '0;
      col_q            <= '0;
      fm_addr_q        <= '0;
      dense_start_q    <= 1'b0;
      dense_idx_q      <= '0;
      image_release_q  <= 1'b0;
      result_valid_q   <= 1'b0;
      result_class_q   <= '0;
      result_score_q   <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      start_rejected_q <= start_rejected_d;
      conv_start_q     <= conv_start_d;
      filt_q           <= filt_d;
      row_q            <= row_d;
      col_q            <= col_d;
      fm_addr_q        <= fm_addr_d;
      dense_start_q    <= dense_start_d;
      dense_idx_q      <= dense_idx_d;
      image_release_q  <= image_release_d;
      result_valid_q   <= result_valid_d;
      result_class_q   <= result_class_d;
      result_score_q   <= result_score_d;
    end
  end

  assign busy           = busy_q;
  assign start_rejected = start_rejected_q;
  assign conv_start     = conv_start_q;
  assign conv_filt      = filt_q;
  assign conv_row       = row_q;
  assign conv_col       = col_q;
  assign fm_addr        = fm_addr_q;
  assign dense_start    = dense_start_q;
  assign dense_idx      = dense_idx_q;
  assign image_release  = image_release_q;
  assign result_valid   = result_valid_q;
  assign result_class   = result_class_q;
  assign result_score   = result_score_q;

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// Bench for cnn_inference_sequencer: stub conv/dense engines answer one
// cycle after each launch, a scoreboard holds the expected pixel order,
// neuron order and final result, and a table of dense result vectors
// drives complete inferences.
module tb_cnn_inference_sequencer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst, weights_ready, image_ready, start;
  logic start_rejected, busy, conv_start, conv_done;
  logic [1:0] conv_filt;
  logic [4:0] conv_row, conv_col;
  logic [11:0] fm_addr;
  logic dense_start, dense_done, image_release, result_valid;
  logic [3:0] dense_idx, result_class;
  logic signed [31:0] dense_acc, result_score;

  cnn_inference_sequencer dut (
    .clk(clk), .rst(rst), .weights_ready(weights_ready), .image_ready(image_ready),
    .start(start), .start_rejected(start_rejected), .busy(busy),
    .conv_start(conv_start), .conv_filt(conv_filt), .conv_row(conv_row),
    .conv_col(conv_col), .fm_addr(fm_addr), .conv_done(conv_done),
    .dense_start(dense_start), .dense_idx(dense_idx), .dense_done(dense_done),
    .dense_acc(dense_acc), .image_release(image_release),
    .result_valid(result_valid), .result_class(result_class),
    .result_score(result_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc [10];
    int exp_cls;
    int exp_score;
  } vec_t;
  vec_t vecs [4];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [23:0] conv_q [$];
  logic [3:0]  dense_q [$];
  int          cls_q [$];
  int          score_q [$];

  int cur_acc [10];
  int cs_cnt, ds_cnt, ir_cnt, rv_cnt, rej_cnt, gap_err, last_cs, first_cs;
  bit conv_pend, dense_pend, spur_conv, spur_dense;
  logic [3:0] dense_pend_idx;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: sample DUT at the falling edge, score it, then drive the stubs.
  task automatic tick();
    logic [23:0] exp_c;
    @(negedge clk);
    cyc++;
    if (conv_start) begin
      if (last_cs < 0) first_cs = cyc;
      else if (cyc - last_cs != 3) gap_err++;
      last_cs = cyc;
      cs_cnt++;
      if (conv_q.size() == 0) check("conv_start_unexpected", cs_cnt, 0);
      else begin
        exp_c = conv_q.pop_front();
        if (cs_cnt <= 2 || cs_cnt % 676 <= 1 || cs_cnt >= 2703 || {conv_filt, conv_row, conv_col, fm_addr} != exp_c)
          check("conv_coord", {conv_filt, conv_row, conv_col, fm_addr}, exp_c);
      end
    end
    if (dense_start) begin
      ds_cnt++;
      if (dense_q.size() == 0) check("dense_start_unexpected", ds_cnt, 0);
      else check("dense_idx", dense_idx, dense_q.pop_front());
    end
    if (image_release) begin
      ir_cnt++;
      check("release_after_last_conv", {cs_cnt, ds_cnt}, {32'd2704, 32'd0});
    end
    if (start_rejected) rej_cnt++;
    if (result_valid) begin
      rv_cnt++;
      check("busy_low_with_result", busy, 0);
      if (cls_q.size() == 0) check("result_unexpected", rv_cnt, 0);
      else begin
        check("result_class", result_class, cls_q.pop_front());
        check("result_score", longint'(result_score), longint'(score_q.pop_front()));
      end
    end
    conv_done  = conv_pend | spur_conv;
    conv_pend  = conv_start;
    dense_done = dense_pend | spur_dense;
    dense_acc  = spur_dense ? 32'sd999 : (dense_pend ? cur_acc[dense_pend_idx] : 32'sd0);
    dense_pend = dense_start;
    dense_pend_idx = dense_idx;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_conv_start"}, conv_start, 0);
    check({tag, "_coord"}, {conv_filt, conv_row, conv_col, fm_addr}, 0);
    check({tag, "_dense"}, {dense_start, dense_idx}, 0);
    check({tag, "_pulses"}, {image_release, result_valid, start_rejected}, 0);
    check({tag, "_result"}, {result_class, result_score}, 0);
  endtask

  // Full inference with vector v; optional mid-run disturbances; optional
  // reset after abort_at conv launches.
  task automatic run_inf(input int v, input bit spur, input int abort_at);
    int start_cyc, a;
    bit got, spur_done;
    for (int i = 0; i < 10; i++) cur_acc[i] = vecs[v].acc[i];
    a = 0;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++) begin
          conv_q.push_back({2'(f), 5'(r), 5'(c), 12'(a)});
          a++;
        end
    for (int i = 0; i < 10; i++) dense_q.push_back(4'(i));
    cls_q.push_back(vecs[v].exp_cls);
    score_q.push_back(vecs[v].exp_score);
    cs_cnt = 0; ds_cnt = 0; ir_cnt = 0; rv_cnt = 0; gap_err = 0;
    last_cs = -1; first_cs = -1; spur_done = 0; got = 0;
    weights_ready = 1; image_ready = 1; start = 1;
    start_cyc = cyc;
    tick();
    start = 0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < 12000 && !got; k++) begin
      if (spur && !spur_done && cs_cnt == 500) begin
        spur_dense = 1; start = 1; image_ready = 0; weights_ready = 0;
        tick();
        spur_dense = 0; start = 0;
        spur_done = 1;
      end
      if (abort_at >= 0 && cs_cnt == abort_at) begin
        rst = 1;
        tick();
        rst = 0;
        check_all_zero("abort");
        conv_q.delete(); dense_q.delete(); cls_q.delete(); score_q.delete();
        for (int j = 0; j < 6; j++) tick();
        check("abort_no_more_conv", cs_cnt, abort_at);
        check("abort_idle", {busy, dense_start, image_release, result_valid}, 0);
        return;
      end
      tick();
      if (rv_cnt > 0) got = 1;
    end
    check("run_completed", got, 1);
    for (int j = 0; j < 4; j++) tick();
    check("first_conv_latency", first_cs - start_cyc, 2);
    check("conv_gap_errors", gap_err, 0);
    check("conv_start_count", cs_cnt, 2704);
    check("dense_start_count", ds_cnt, 10);
    check("image_release_count", ir_cnt, 1);
    check("result_valid_count", rv_cnt, 1);
    check("busy_idle_after", busy, 0);
    check("result_class_held", result_class, vecs[v].exp_cls);
    check("scoreboard_empty", conv_q.size() + dense_q.size() + cls_q.size(), 0);
  endtask

  initial begin
    vecs[0].acc = '{5, -3, 100, 7, 100, 0, -1, 99, 2, 3};
    vecs[0].exp_cls = 2;  vecs[0].exp_score = 100;
    vecs[1].acc = '{-50, -8, -9, -20, -8, -100, -30, -8, -60, -70};
    vecs[1].exp_cls = 1;  vecs[1].exp_score = -8;
    vecs[2].acc = '{32'sh80000000, -1, -1, -1, -1, -1, -1, -1, -1, 32'sh7fffffff};
    vecs[2].exp_cls = 9;  vecs[2].exp_score = 32'sh7fffffff;
    vecs[3].acc = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
    vecs[3].exp_cls = 0;  vecs[3].exp_score = 42;

    rst = 1; weights_ready = 0; image_ready = 0; start = 0;
    conv_done = 0; dense_done = 0; dense_acc = 0;
    conv_pend = 0; dense_pend = 0; spur_conv = 0; spur_dense = 0; dense_pend_idx = 0;
    cs_cnt = 0; ds_cnt = 0; ir_cnt = 0; rv_cnt = 0; rej_cnt = 0;
    gap_err = 0; last_cs = -1; first_cs = -1;
    for (int j = 0; j < 3; j++) tick();
    rst = 0;
    tick();
    check_all_zero("reset");

    // Start without weights is rejected; a stray conv_done in IDLE is ignored.
    image_ready = 1; weights_ready = 0; start = 1;
    tick();
    start = 0;
    check("start_rejected_pulse", start_rejected, 1);
    check("rejected_busy", busy, 0);
    tick();
    check("start_rejected_one_cycle", start_rejected, 0);
    spur_conv = 1;
    tick();
    spur_conv = 0;
    for (int j = 0; j < 4; j++) tick();
    check("no_conv_after_reject", cs_cnt, 0);
    check("reject_count", rej_cnt, 1);

    // Table of complete inferences.
    run_inf(0, 0, -1);
    run_inf(1, 1, -1);
    run_inf(2, 0, 1000);
    run_inf(2, 0, -1);
    run_inf(3, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
